avalon_pio_in_debounced: RTL and testbench

- Parametrised Avalon-MM input PIO for pushbuttons and switches.
- Data path per channel: 2-FF synchroniser, then counter-based debouncer, then edge detector with selectable edge type.
- Per-bit edge-capture register (write-1-to-clear) and per-bit interrupt mask drive a level IRQ to the Nios II interrupt controller.
- Sits on the system interconnect as a 4-word slave; successor to the plain 4-bit edge-capture button PIO.

---
 rtl/pio_pkg.sv | 23 ++
 rtl/pio_debounce_ch.sv | 73 +++++++
 rtl/avalon_pio_in_debounced.sv | 132 +++++++++++++
 tb/tb_avalon_pio_in_debounced.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// ---------------------------------------------------------------------------
// pio_pkg
// Shared definitions for the debounced Avalon-MM input PIO:
//   - word offsets of the four slave registers
//   - encoding of the EDGE_MODE register
// ---------------------------------------------------------------------------
package pio_pkg;

    // Register word offsets on the 2-bit Avalon address bus
    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_EDGE_MODE = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP  = 2'd3;

    // Which debounced transitions are recorded in EDGE_CAPTURE
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_mode_e;

endpackage : pio_pkg

// File: rtl/pio_debounce_ch.sv
// ---------------------------------------------------------------------------
// pio_debounce_ch
// One input channel: 2-FF synchroniser, counter-based debouncer and a
// one-cycle-delayed copy of the debounced value for edge detection.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset
//   in_pin   in   raw asynchronous pin
//   stable   out  debounced level
//   rise     out  one-cycle pulse after stable goes 0->1
//   fall     out  one-cycle pulse after stable goes 1->0
// ---------------------------------------------------------------------------
module pio_debounce_ch #(
    parameter  int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             stable_q;

    // Synchroniser: in_pin -> sync1 -> sync2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in_pin;
            sync2 <= sync1;
        end
    end

    // Debouncer: the synchronised value must differ from stable for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the stable value
    // restarts the count. The count stops at CNT_LAST, so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Edge detector register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
        end
    end

    assign rise = stable & ~stable_q;
    assign fall = ~stable & stable_q;

endmodule : pio_debounce_ch

// File: rtl/avalon_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// avalon_pio_in_debounced
// Avalon-MM input PIO for pushbuttons/switches with per-channel debounce,
// selectable edge capture (write-1-to-clear), per-bit interrupt mask and a
// level interrupt output.
//
// Register map (word offsets):
//   0 DATA          R    debounced levels
//   1 EDGE_MODE     R/W  0 rise, 1 fall, 2 both, 3 capture disabled
//   2 IRQ_MASK      R/W  per-bit interrupt enable
//   3 EDGE_CAPTURE  R/W1C sticky edge flags
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous, active-low reset
//   address     in   word offset
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  registered read data (1-cycle latency)
//   in_port     in   raw asynchronous pins
//   irq         out  level interrupt, active-high
// ---------------------------------------------------------------------------
module avalon_pio_in_debounced
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    edge_mode_e       edge_mode;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    logic             wr_en;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_next;

    // Upper writedata bits beyond WIDTH have no destination
    logic             unused_wdata;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .in_pin (in_port[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        cap_set = '0;
        case (edge_mode)
            EDGE_RISE: cap_set = rise;
            EDGE_FALL: cap_set = fall;
            EDGE_BOTH: cap_set = rise | fall;
            default:   cap_set = '0;
        endcase
    end

    assign cap_clr = (wr_en && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

    // Control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_mode <= EDGE_RISE;
            irq_mask  <= '0;
        end else if (wr_en) begin
            if (address == ADDR_EDGE_MODE) begin
                edge_mode <= edge_mode_e'(writedata[1:0]);
            end
            if (address == ADDR_IRQ_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Clear is applied before set, so a new edge in the same cycle as a
    // write-1-clear of that bit is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~cap_clr) | cap_set;
        end
    end

    // Read mux is registered every cycle regardless of chipselect
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:      rd_next[WIDTH-1:0] = stable;
            ADDR_EDGE_MODE: rd_next[1:0]       = edge_mode;
            ADDR_IRQ_MASK:  rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP:  rd_next[WIDTH-1:0] = edge_capture;
            default:        rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule : avalon_pio_in_debounced

// File: tb/tb_avalon_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_in_debounced
// Directed bench for avalon_pio_in_debounced with WIDTH=4, DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_avalon_pio_in_debounced;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    avalon_pio_in_debounced #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        address = a;
        cyc(1);
        v = readdata;
    endtask

    // Drop all pins, let them settle, clear every capture bit
    task automatic release_and_clear();
        in_port = 4'b0000;
        cyc(12);
        bus_write(2'd3, 32'hF);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'b0000;
        cyc(2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b exp 0", irq);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL reset_readdata got %h exp 0", readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], v);
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL reset_read_off%0d got %h exp 0", a, v);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] v;
        address = 2'd0;
        in_port = 4'b0001;      // settled before edge k
        cyc(6);                 // edges k..k+5: stable changes at k+5
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL press_data_early got %h exp 0", readdata);
        end
        cyc(1);                 // edge k+6 registers the new DATA
        checks++;
        if (readdata !== 32'h1) begin
            errors++; $display("FAIL press_data got %h exp 1", readdata);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL press_cap got %h exp 1", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL press_irq_masked got %b exp 0", irq);
        end
        release_and_clear();
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        address = 2'd0;
        in_port = 4'b0010;
        cyc(3);
        in_port = 4'b0000;
        cyc(1);
        in_port = 4'b0010;      // last rise, before edge k+4
        cyc(6);                 // stable changes at k+9; readdata still old
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL bounce_data_early got %h exp 0", readdata);
        end
        cyc(1);
        checks++;
        if (readdata !== 32'h2) begin
            errors++; $display("FAIL bounce_data got %h exp 2", readdata);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL bounce_cap got %h exp 2", v);
        end
        bus_write(2'd3, 32'h2);
        cyc(10);
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL bounce_single_cap got %h exp 0", v);
        end
        release_and_clear();
    endtask

    task automatic test_fall_irq();
        logic [31:0] v;
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h8);
        in_port = 4'b1000;
        cyc(12);
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL fall_no_press_cap got %h exp 0", v);
        end
        in_port = 4'b0000;      // release before edge k
        cyc(6);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL fall_irq_early got %b exp 0", irq);
        end
        cyc(1);                 // edge k+6 sets capture
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL fall_irq got %b exp 1", irq);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h8) begin
            errors++; $display("FAIL fall_cap got %h exp 8", v);
        end
        bus_write(2'd3, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL fall_irq_cleared got %b exp 0", irq);
        end
    endtask

    task automatic test_mask_mode_regs();
        logic [31:0] v;
        // mode is still falling; press ignored, release captured while masked
        bus_write(2'd2, 32'h0);
        in_port = 4'b1000;
        cyc(12);
        in_port = 4'b0000;
        cyc(12);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL masked_irq got %b exp 0", irq);
        end
        bus_write(2'd1, 32'h0);
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h8) begin
            errors++; $display("FAIL mode_change_keeps_cap got %h exp 8", v);
        end
        bus_write(2'd2, 32'h8);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL unmask_irq got %b exp 1", irq);
        end
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'hF) begin
            errors++; $display("FAIL mask_readback got %h exp f", v);
        end
        bus_write(2'd1, 32'hFFFF_FFFE);
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL mode_readback got %h exp 2", v);
        end
        bus_write(2'd0, 32'hF);
        bus_read(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL data_write_ignored got %h exp 0", v);
        end
        bus_write(2'd3, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_all_mask_clear got %b exp 0", irq);
        end
        // capture disabled: neither edge recorded
        bus_write(2'd1, 32'h3);
        in_port = 4'b0001;
        cyc(12);
        in_port = 4'b0000;
        cyc(12);
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL mode_off_cap got %h exp 0", v);
        end
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_collision();
        logic [31:0] v;
        in_port = 4'b0011;
        cyc(12);
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h3) begin
            errors++; $display("FAIL two_caps got %h exp 3", v);
        end
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL w1c_bit1_only got %h exp 1", v);
        end
        in_port = 4'b0010;
        cyc(12);
        in_port = 4'b0011;      // before edge k; capture sets at k+6
        cyc(6);
        bus_write(2'd3, 32'h1); // clear lands on edge k+6
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL collide_set_wins got %h exp 1", v);
        end
    endtask

    task automatic test_reset_mid();
        in_port = 4'b0000;
        cyc(12);
        bus_write(2'd2, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL pre_reset_irq got %b exp 1", irq);
        end
        address = 2'd3;
        cyc(1);
        in_port = 4'b0001;      // before edge k
        cyc(4);                 // edges k..k+3: count now 2
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_readdata got %h exp 0", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL mid_reset_irq got %b exp 0", irq);
        end
        cyc(2);
        reset_n = 1'b1;
        // edge 0 after release carries the mask write
        bus_write(2'd2, 32'h1);
        cyc(5);                 // edges 1..5
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL rst_cap_early got %b exp 0", irq);
        end
        cyc(1);                 // edge 6 sets capture
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL rst_cap got %b exp 1", irq);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_fall_irq();
        test_mask_mode_regs();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_avalon_pio_in_debounced
